data_memory_ctrl: RTL and testbench
===================================

// Module: data_memory_ctrl
// PURPOSE
//   Parametrised, byte-addressed, big-endian data memory for the CPU datapath.
//   Supports byte, halfword and word loads and stores, with sign or zero extension.
//   Accesses use a Req/Ready handshake with a configurable number of wait states,
//   so the multi-cycle control unit can stall on memory.
//   Contains the write-back mux: WBdata = load data, or the latched address (ALU result).
// PARAMETERS
//   DEPTH_BYTES  64  memory size in bytes; power of 2, >= 4
//   WAIT_CYCLES  1   extra cycles between request accept and Ready; 0..15
// PORTS
//   CLK      in   1   clock; all state changes on the rising edge
//   Reset_n  in   1   asynchronous, active-low reset
//   Req      in   1   access request; sampled only in IDLE
//   Write    in   1   1 = store, 0 = load; sampled with Req
//   Size     in   2   00 = byte, 01 = halfword, 10 = word, 11 = reserved (Fault)
//   Unsigned in   1   load extension: 1 = zero-extend, 0 = sign-extend
//   WBsrc    in   1   1 = WBdata is load data; 0 = WBdata is the latched DAddr
//   DAddr    in   32  byte address; sampled with Req
//   DataIn   in   32  store data, right-aligned (byte in [7:0], half in [15:0])
//   Ready    out  1   one-cycle pulse: access complete, WBdata/Fault valid
//   Busy     out  1   high from accept until the cycle after Ready
//   WBdata   out  32  write-back data; held until the next Ready
//   Fault    out  1   access rejected; valid with Ready, held until the next Ready
// BEHAVIOUR
//   Reset (async, Reset_n=0):
//     - state=IDLE, wait counter=0
//     - Ready=0, Busy=0, WBdata=0, Fault=0
//     - RAM contents are NOT cleared
//   FSM states: IDLE, WAIT, DONE.
//     - IDLE & Req: latch Write/Size/Unsigned/WBsrc/DAddr/DataIn.
//       Go to WAIT with counter=WAIT_CYCLES, or straight to DONE if WAIT_CYCLES=0.
//     - WAIT: decrement the counter; go to DONE when it reaches 1.
//     - DONE: Ready=1 for exactly one cycle, then return to IDLE.
//   Latency: Ready is asserted WAIT_CYCLES+1 cycles after the accept edge.
//     Back-to-back issue: next accept is possible one cycle after Ready.
//   Req outside IDLE: ignored, not queued; Req must be held until accepted.
//   Store commit: on the edge entering DONE, only when there is no fault.
//     - Big-endian: MSB at the lowest address.
//     - Byte: ram[A] = DataIn[7:0].
//     - Half: ram[A..A+1] = DataIn[15:0].
//     - Word: ram[A..A+3] = DataIn[31:0].
//   Load data: read from the latched address on the edge entering DONE.
//     Extended to 32 bits per Unsigned.
//   Write-back mux: WBdata = WBsrc ? load data : latched DAddr.
//     - For a store with WBsrc=1, WBdata=0.
//   Fault conditions (no RAM write; load data forced to 0):
//     - A+size-1 >= DEPTH_BYTES (no wrap-around)
//     - Size=11
//     - misalignment, when DMEM_MISALIGN_CHECK_EN is defined
//   Arithmetic: range check uses full 33-bit compare; no truncation of DAddr.
//   Reset mid-access: pending store is discarded and no partial bytes are written.
//     Any bytes already committed on earlier accesses remain.
// CONFIGURATION
//   DMEM_MISALIGN_CHECK_EN
//     - defined: misaligned access faults.
//       Misaligned = halfword with A[0]=1, or word with A[1:0]!=0.
//     - undefined: misaligned in-range accesses proceed byte-wise at A, A+1, ...
//       with no fault. The range check still applies.
// TESTING
//   1. Word round-trip, WAIT_CYCLES=1: store 0x12345678 @0x10, then load word @0x10
//      -> Ready 2 cycles after accept; WBdata=0x12345678; ram[0x10]=0x12.
//   2. Byte/half extension: store byte 0x80 @0x20.
//      -> Signed byte load gives 0xFFFFFF80; Unsigned gives 0x00000080.
//      -> Half load @0x20 (after storing 0x80 @0x21) gives 0xFFFF8080.
//   3. Bounds: word load @0x3D with DEPTH_BYTES=64
//      -> Fault=1, WBdata=0; store @0x3D leaves ram[0x3D..0x3F] unchanged.
//   4. Misalign: word store @0x11.
//      -> Macro defined: Fault=1, no write.
//      -> Macro undefined: Fault=0, bytes written at 0x11..0x14.
//   5. Handshake/WBsrc: Req held during WAIT is ignored; a single Ready results.
//      -> Load with WBsrc=0 @0x24 gives WBdata=0x00000024.
//      -> Req held high issues the next access one cycle after Ready.
//   6. Reset mid-op: assert Reset_n=0 during WAIT of a store of 0xDEADBEEF @0x08
//      -> Ready/Busy/WBdata = 0 at once; ram[0x08..0x0B] keeps its old value.

Source files
------------

// File: rtl/data_memory_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// data_memory_ctrl : big-endian byte-addressed data RAM, Req/Ready handshake
//   with wait states and write-back mux. Option: DMEM_MISALIGN_CHECK_EN.
// Revision: 1.0
// ---------------------------------------------------------------------------
module data_memory_ctrl #(
  parameter int DEPTH_BYTES = 64,
  parameter int WAIT_CYCLES = 1
) (
  input  logic        CLK,
  input  logic        Reset_n,
  input  logic        Req,
  input  logic        Write,
  input  logic [1:0]  Size,
  input  logic        Unsigned,
  input  logic        WBsrc,
  input  logic [31:0] DAddr,
  input  logic [31:0] DataIn,
  output logic        Ready,
  output logic        Busy,
  output logic [31:0] WBdata,
  output logic        Fault
);

  localparam int AW = $clog2(DEPTH_BYTES);
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]    state, state_nxt;
  logic [3:0]    wait_cnt;
  logic          lat_write, lat_unsigned, lat_wbsrc;
  logic [1:0]    lat_size;
  logic [31:0]   lat_addr, lat_data;
  logic [7:0]    ram [DEPTH_BYTES];

  logic          use_in, a_write, a_unsigned, a_wbsrc;
  logic [1:0]    a_size;
  logic [31:0]   a_addr, a_data;
  logic [2:0]    nbytes;
  logic [32:0]   last_addr;
  logic          misalign, access_fault, enter_done;
  logic [AW-1:0] byte_idx [4];
  logic [7:0]    ld_b [4];
  logic [7:0]    st_b [4];
  logic [3:0]    byte_en;
  logic [31:0]   load_ext, wb_next;

  // State register
  always_ff @(posedge CLK or negedge Reset_n) begin
    if (!Reset_n) begin
      state    <= S_IDLE;
      wait_cnt <= 4'd0;
    end else begin
      state <= state_nxt;
      if (state == S_IDLE && Req)
        wait_cnt <= 4'(WAIT_CYCLES);
      else if (state == S_WAIT)
        wait_cnt <= wait_cnt - 4'd1;
    end
  end

  always_comb begin
    state_nxt = S_IDLE;
    case (state)
      S_IDLE:  state_nxt = Req ? ((WAIT_CYCLES == 0) ? S_DONE : S_WAIT) : S_IDLE;
      S_WAIT:  state_nxt = (wait_cnt <= 4'd1) ? S_DONE : S_WAIT;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    Ready = (state == S_DONE);
    Busy  = (state != S_IDLE);
  end

  // With zero wait states DONE is entered straight from IDLE, so the live inputs are used
  always_comb begin
    use_in     = (state == S_IDLE);
    a_write    = use_in ? Write    : lat_write;
    a_size     = use_in ? Size     : lat_size;
    a_unsigned = use_in ? Unsigned : lat_unsigned;
    a_wbsrc    = use_in ? WBsrc    : lat_wbsrc;
    a_addr     = use_in ? DAddr    : lat_addr;
    a_data     = use_in ? DataIn   : lat_data;
  end

`ifdef DMEM_MISALIGN_CHECK_EN
  assign misalign = ((a_size == 2'b01) && a_addr[0]) ||
                    ((a_size == 2'b10) && (a_addr[1:0] != 2'b00));
`else
  assign misalign = 1'b0;
`endif

  always_comb begin
    case (a_size)
      2'b00:   nbytes = 3'd1;
      2'b01:   nbytes = 3'd2;
      default: nbytes = 3'd4;
    endcase
    last_addr    = {1'b0, a_addr} + {30'd0, nbytes} - 33'd1;
    access_fault = (last_addr >= 33'(DEPTH_BYTES)) || (a_size == 2'b11) || misalign;
    enter_done   = (state_nxt == S_DONE) && (state != S_DONE);
  end

  always_comb begin
    for (int k = 0; k < 4; k++) begin
      byte_idx[k] = a_addr[AW-1:0] + AW'(k);
      ld_b[k]     = ram[byte_idx[k]];
      byte_en[k]  = (3'(k) < nbytes);
      st_b[k]     = 8'h00;
    end
    case (a_size)
      2'b00: st_b[0] = a_data[7:0];
      2'b01: begin
        st_b[0] = a_data[15:8];
        st_b[1] = a_data[7:0];
      end
      default: begin
        st_b[0] = a_data[31:24];
        st_b[1] = a_data[23:16];
        st_b[2] = a_data[15:8];
        st_b[3] = a_data[7:0];
      end
    endcase
    case (a_size)
      2'b00:   load_ext = {{24{~a_unsigned & ld_b[0][7]}}, ld_b[0]};
      2'b01:   load_ext = {{16{~a_unsigned & ld_b[0][7]}}, ld_b[0], ld_b[1]};
      default: load_ext = {ld_b[0], ld_b[1], ld_b[2], ld_b[3]};
    endcase
    wb_next = a_wbsrc ? ((a_write || access_fault) ? 32'd0 : load_ext) : a_addr;
  end

  always_ff @(posedge CLK or negedge Reset_n) begin
    if (!Reset_n) begin
      lat_write    <= 1'b0;
      lat_size     <= 2'b00;
      lat_unsigned <= 1'b0;
      lat_wbsrc    <= 1'b0;
      lat_addr     <= 32'd0;
      lat_data     <= 32'd0;
      WBdata       <= 32'd0;
      Fault        <= 1'b0;
    end else begin
      if (state == S_IDLE && Req) begin
        lat_write    <= Write;
        lat_size     <= Size;
        lat_unsigned <= Unsigned;
        lat_wbsrc    <= WBsrc;
        lat_addr     <= DAddr;
        lat_data     <= DataIn;
      end
      if (enter_done) begin
        WBdata <= wb_next;
        Fault  <= access_fault;
      end
    end
  end

  // RAM has no reset; the Reset_n gate keeps an aborted store from landing
  always_ff @(posedge CLK) begin
    if (Reset_n && enter_done && a_write && !access_fault) begin
      for (int k = 0; k < 4; k++)
        if (byte_en[k]) ram[byte_idx[k]] <= st_b[k];
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_data_memory_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_data_memory_ctrl : vector table plus handshake/reset sequences.
// Revision: 1.0
// ---------------------------------------------------------------------------
module tb_data_memory_ctrl;

  localparam int W = 1;
`ifdef DMEM_MISALIGN_CHECK_EN
  localparam bit MIS = 1'b1;
`else
  localparam bit MIS = 1'b0;
`endif

  logic        CLK = 1'b0;
  logic        Reset_n, Req, Write, Unsigned, WBsrc;
  logic [1:0]  Size;
  logic [31:0] DAddr, DataIn;
  logic        Ready, Busy, Fault;
  logic [31:0] WBdata;

  always #5 CLK = ~CLK;

  data_memory_ctrl #(.DEPTH_BYTES(64), .WAIT_CYCLES(W)) dut (
    .CLK(CLK), .Reset_n(Reset_n), .Req(Req), .Write(Write), .Size(Size),
    .Unsigned(Unsigned), .WBsrc(WBsrc), .DAddr(DAddr), .DataIn(DataIn),
    .Ready(Ready), .Busy(Busy), .WBdata(WBdata), .Fault(Fault)
  );

  typedef struct {
    logic        wr;
    logic [1:0]  sz;
    logic        uns;
    logic        wbs;
    logic [31:0] addr;
    logic [31:0] data;
    logic [31:0] exp_wb;
    logic        exp_f;
  } vec_t;

  typedef struct {
    logic [31:0] wb;
    logic        f;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic add(input logic wr, input logic [1:0] sz, input logic uns, input logic wbs,
                     input logic [31:0] addr, input logic [31:0] data,
                     input logic [31:0] exp_wb, input logic exp_f);
    vec_t v;
    v.wr = wr; v.sz = sz; v.uns = uns; v.wbs = wbs;
    v.addr = addr; v.data = data; v.exp_wb = exp_wb; v.exp_f = exp_f;
    vecs.push_back(v);
  endtask

  task automatic drive(input vec_t v);
    Write = v.wr; Size = v.sz; Unsigned = v.uns; WBsrc = v.wbs;
    DAddr = v.addr; DataIn = v.data; Req = 1'b1;
  endtask

  task automatic pop_check(input string name);
    exp_t e;
    if (sb.size() == 0) begin
      n_checks++; n_fail++;
      $display("FAIL %s: unexpected Ready, scoreboard empty", name);
    end else begin
      e = sb.pop_front();
      check({name, ".wb"}, WBdata, e.wb);
      check({name, ".fault"}, {31'd0, Fault}, {31'd0, e.f});
    end
  endtask

  task automatic run_vec(input vec_t v, input string name);
    int cyc;
    exp_t e;
    @(negedge CLK);
    drive(v);
    e.wb = v.exp_wb; e.f = v.exp_f;
    sb.push_back(e);
    @(posedge CLK);
    #1 Req = 1'b0;
    cyc = 0;
    do begin
      @(negedge CLK);
      cyc++;
    end while (!Ready && cyc < 40);
    check({name, ".latency"}, 32'(cyc), 32'(W + 1));
    if (Ready) begin
      check({name, ".busy"}, {31'd0, Busy}, 32'd1);
      pop_check(name);
    end else begin
      void'(sb.pop_front());
    end
    @(negedge CLK);
    check({name, ".pulse"}, {30'd0, Ready, Busy}, 32'd0);
  endtask

  initial begin
    int   first, second, readys;
    exp_t e;
    vec_t v;

    // wr sz uns wbs addr data exp_wb exp_fault
    add(1, 2'b10, 0, 1, 32'h10, 32'h12345678, 32'h0,        0);
    add(0, 2'b10, 0, 1, 32'h10, 32'h0,        32'h12345678, 0);
    add(0, 2'b00, 1, 1, 32'h10, 32'h0,        32'h12,       0);
    add(1, 2'b00, 0, 1, 32'h20, 32'h80,       32'h0,        0);
    add(0, 2'b00, 0, 1, 32'h20, 32'h0,        32'hFFFFFF80, 0);
    add(0, 2'b00, 1, 1, 32'h20, 32'h0,        32'h00000080, 0);
    add(1, 2'b00, 0, 1, 32'h21, 32'h80,       32'h0,        0);
    add(0, 2'b01, 0, 1, 32'h20, 32'h0,        32'hFFFF8080, 0);
    add(0, 2'b01, 1, 1, 32'h20, 32'h0,        32'h00008080, 0);
    add(1, 2'b10, 0, 1, 32'h3C, 32'hA1B2C3D4, 32'h0,        0);
    add(0, 2'b10, 0, 1, 32'h3D, 32'h0,        32'h0,        1);
    add(1, 2'b10, 0, 1, 32'h3D, 32'h11223344, 32'h0,        1);
    add(1, 2'b01, 0, 1, 32'h3F, 32'h5566,     32'h0,        1);
    add(0, 2'b10, 0, 1, 32'h3C, 32'h0,        32'hA1B2C3D4, 0);
    add(0, 2'b00, 1, 1, 32'h3F, 32'h0,        32'hD4,       0);
    add(0, 2'b11, 0, 1, 32'h00, 32'h0,        32'h0,        1);
    add(0, 2'b10, 0, 0, 32'h24, 32'h0,        32'h24,       0);
    add(0, 2'b10, 0, 0, 32'h3D, 32'h0,        32'h3D,       1);
    add(1, 2'b00, 0, 0, 32'h30, 32'h0,        32'h30,       0);
    add(0, 2'b00, 0, 1, 32'h80000000, 32'h0,  32'h0,        1);
    add(0, 2'b10, 0, 1, 32'hFFFFFFFF, 32'h0,  32'h0,        1);
    add(1, 2'b10, 0, 1, 32'h08, 32'h01020304, 32'h0,        0);
    add(1, 2'b10, 0, 1, 32'h11, 32'hCAFEF00D, 32'h0,        MIS);
    add(0, 2'b00, 1, 1, 32'h11, 32'h0,        MIS ? 32'h34 : 32'hCA, 0);
    add(0, 2'b10, 0, 1, 32'h10, 32'h0,        MIS ? 32'h12345678 : 32'h12CAFEF0, 0);

    Reset_n = 1'b0; Req = 1'b0; Write = 1'b0; Size = 2'b00; Unsigned = 1'b0;
    WBsrc = 1'b0; DAddr = 32'd0; DataIn = 32'd0;
    repeat (3) @(negedge CLK);
    check("reset.outputs", {WBdata[31:3], Ready, Busy, Fault}, 32'd0);
    check("reset.wbdata", WBdata, 32'd0);
    Reset_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++)
      run_vec(vecs[i], $sformatf("vec%0d", i));

    // Req held high: ignored during WAIT, re-issued one cycle after Ready
    @(negedge CLK);
    v.wr = 0; v.sz = 2'b10; v.uns = 0; v.wbs = 0; v.addr = 32'h24; v.data = 0;
    drive(v);
    e.wb = 32'h24; e.f = 1'b0;
    sb.push_back(e);
    sb.push_back(e);
    first = -1; second = -1; readys = 0;
    for (int c = 1; c <= 10; c++) begin
      @(negedge CLK);
      if (Ready) begin
        readys++;
        if (first < 0) first = c; else if (second < 0) second = c;
        pop_check($sformatf("hold.r%0d", readys));
        if (readys == 2) Req = 1'b0;
      end
    end
    check("hold.first", 32'(first), 32'(W + 1));
    check("hold.second", 32'(second), 32'(2 * W + 3));
    check("hold.count", 32'(readys), 32'd2);

    // Reset during WAIT of a store: outputs clear at once, RAM unchanged
    @(negedge CLK);
    v.wr = 1; v.sz = 2'b10; v.uns = 0; v.wbs = 1; v.addr = 32'h08; v.data = 32'hDEADBEEF;
    drive(v);
    @(posedge CLK);
    #1 Req = 1'b0;
    #1 Reset_n = 1'b0;
    #1;
    check("rst_mid.ready_busy_fault", {29'd0, Ready, Busy, Fault}, 32'd0);
    check("rst_mid.wbdata", WBdata, 32'd0);
    @(posedge CLK);
    @(negedge CLK);
    Reset_n = 1'b1;
    sb.delete();
    v.wr = 0; v.sz = 2'b10; v.uns = 0; v.wbs = 1; v.addr = 32'h08; v.data = 0;
    v.exp_wb = 32'h01020304; v.exp_f = 1'b0;
    run_vec(v, "rst_mid.readback");

    check("sb.empty", 32'(sb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
